video_timing_gen: RTL and testbench

- Generates raster timing for the DVI output path: pixel/line counters, hSync, vSync and vde.
- Drives the TMDS serializer stage directly.
- Exposes undelayed pixel coordinates so the upstream pixel source (VDP framebuffer lookup) can fetch data, and delays the sync/enable outputs by a fixed pipeline depth so they line up with that data.
- Runs in the pixclk domain.

---
 rtl/video_timing_gen.sv | 106 ++++++++++
 tb/tb_video_timing_gen.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | video_timing_gen: raster pixel/line counters with delayed sync/vde        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int LATENCY  = 2
) (
  input  logic       pixclk,
  input  logic       reset,
  input  logic       ce,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       line_start,
  output logic       frame_start,
  output logic       vde,
  output logic       hSync,
  output logic       vSync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] C_H_ACTIVE   = 11'(H_ACTIVE);
  localparam logic [10:0] C_HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] C_HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] C_V_ACTIVE   = 11'(V_ACTIVE);
  localparam logic [10:0] C_VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] C_VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  C_X_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  C_Y_LAST     = 10'(V_TOTAL - 1);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
      $error("video_timing_gen: LATENCY must be within 1..8");
    end
  endgenerate

  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [10:0] w_x_ext;
  logic [10:0] w_y_ext;
  logic        w_de_raw;
  logic        w_hs_raw;
  logic        w_vs_raw;
  // Each stage holds {de, hs, vs} before polarity is applied.
  logic [2:0]  r_pipe [LATENCY];

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (ce) begin
      if (r_x == C_X_LAST) begin
        r_x <= '0;
        r_y <= (r_y == C_Y_LAST) ? '0 : r_y + 10'd1;
      end else begin
        r_x <= r_x + 10'd1;
      end
    end
  end

  assign w_x_ext  = {1'b0, r_x};
  assign w_y_ext  = {1'b0, r_y};
  assign w_de_raw = (w_x_ext < C_H_ACTIVE) && (w_y_ext < C_V_ACTIVE);
  assign w_hs_raw = (w_x_ext >= C_HS_START) && (w_x_ext < C_HS_END);
  assign w_vs_raw = (w_y_ext >= C_VS_START) && (w_y_ext < C_VS_END);

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_pipe[i] <= 3'b000;
      end
    end else if (ce) begin
      r_pipe[0] <= {w_de_raw, w_hs_raw, w_vs_raw};
      for (int i = 1; i < LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign active      = w_de_raw;
  assign line_start  = (r_x == 10'd0);
  assign frame_start = (r_x == 10'd0) && (r_y == 10'd0);
  assign vde         = r_pipe[LATENCY-1][2];
  assign hSync       = r_pipe[LATENCY-1][1] ? HS_POL : ~HS_POL;
  assign vSync       = r_pipe[LATENCY-1][0] ? VS_POL : ~VS_POL;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_video_timing_gen: three timing configs driven in lockstep, scoreboard  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_video_timing_gen;

  localparam int NCYC = 40000;

  typedef logic [25:0] vec_t;
  typedef logic [2:0][25:0] exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;

  logic [9:0] dx [3];
  logic [9:0] dy [3];
  logic dact [3];
  logic dls  [3];
  logic dfs  [3];
  logic dvde [3];
  logic dhs  [3];
  logic dvs  [3];

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  video_timing_gen u_dut0 (
    .pixclk(clk), .reset(rst), .ce(ce), .x(dx[0]), .y(dy[0]), .active(dact[0]),
    .line_start(dls[0]), .frame_start(dfs[0]), .vde(dvde[0]), .hSync(dhs[0]), .vSync(dvs[0])
  );

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .LATENCY(8)
  ) u_dut1 (
    .pixclk(clk), .reset(rst), .ce(ce), .x(dx[1]), .y(dy[1]), .active(dact[1]),
    .line_start(dls[1]), .frame_start(dfs[1]), .vde(dvde[1]), .hSync(dhs[1]), .vSync(dvs[1])
  );

  video_timing_gen #(
    .HS_POL(1'b1), .VS_POL(1'b1), .LATENCY(1)
  ) u_dut2 (
    .pixclk(clk), .reset(rst), .ce(ce), .x(dx[2]), .y(dy[2]), .active(dact[2]),
    .line_start(dls[2]), .frame_start(dfs[2]), .vde(dvde[2]), .hSync(dhs[2]), .vSync(dvs[2])
  );

  // Reference: n = ce-qualified edges since reset; raster position is n mod line/frame,
  // the delayed outputs are the raster decode of position n-LATENCY (idle before that).
  function automatic vec_t model(int c, int n);
    int ha, hf, hsw, hb, va, vf, vsw, vb, lat, ht, vt, xp, yp, m, mx, my;
    bit hp, vp, act, de, h, v;
    if (c == 1) begin
      ha = 16;  hf = 2;  hsw = 3;  hb = 2;  va = 6;   vf = 1;  vsw = 2; vb = 1;
      lat = 8; hp = 1'b1; vp = 1'b1;
    end else begin
      ha = 640; hf = 16; hsw = 96; hb = 48; va = 480; vf = 10; vsw = 2; vb = 33;
      lat = (c == 0) ? 2 : 1;
      hp = (c == 2); vp = (c == 2);
    end
    ht  = ha + hf + hsw + hb;
    vt  = va + vf + vsw + vb;
    xp  = n % ht;
    yp  = (n / ht) % vt;
    act = (xp < ha) && (yp < va);
    de = 1'b0; h = 1'b0; v = 1'b0;
    if (n >= lat) begin
      m  = n - lat;
      mx = m % ht;
      my = (m / ht) % vt;
      de = (mx < ha) && (my < va);
      h  = (mx >= ha + hf) && (mx < ha + hf + hsw);
      v  = (my >= va + vf) && (my < va + vf + vsw);
    end
    return {10'(xp), 10'(yp), act, xp == 0, (xp == 0) && (yp == 0), de,
            h ? hp : ~hp, v ? vp : ~vp};
  endfunction

  initial begin : driver
    int   n;
    logic nrst;
    logic nce;
    exp_t e;
    n = 0;
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      if (rst) n = 0;
      else if (ce) n++;
      if (k < 3) begin
        nrst = 1'b1; nce = 1'b1;
      end else if (k < 12000) begin
        nrst = 1'b0; nce = 1'b1;
      end else if (k < 16000) begin
        nrst = 1'b0; nce = k[0];
      end else begin
        nrst = ($urandom_range(0, 2999) == 0);
        nce  = ($urandom_range(0, 3) != 0);
      end
      if (nrst) n = 0;
      rst = nrst;
      ce  = nce;
      for (int i = 0; i < 3; i++) e[i] = model(i, n);
      q.push_back(e);
      cyc = k;
    end
    repeat (3) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : monitor
    exp_t e;
    vec_t got;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < 3; i++) begin
          got = {dx[i], dy[i], dact[i], dls[i], dfs[i], dvde[i], dhs[i], dvs[i]};
          tests++;
          if (got !== e[i]) begin
            fails++;
            if (fails <= 20)
              $display("FAIL dut%0d cycle %0d: got x=%0d y=%0d act/ls/fs/vde/hs/vs=%b, expected x=%0d y=%0d act/ls/fs/vde/hs/vs=%b",
                       i, cyc, got[25:16], got[15:6], got[5:0], e[i][25:16], e[i][15:6], e[i][5:0]);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
